// File: rtl/cfg_pkg.sv
// cfg_pkg: build-time sizing for the order-book command arbiter.
package cfg_pkg;
    localparam int ARB_PORTS_N    = 2;
    localparam int ARB_INFLIGHT_N = 8;
endpackage

// File: rtl/ob_pkg.sv
// ob_pkg: order-book command/response types and in-flight bookkeeping record.
package ob_pkg;
    typedef logic [31:0] uid_t;
    typedef logic [$clog2(cfg_pkg::ARB_PORTS_N)-1:0] port_id_t;
    typedef enum logic [1:0] {Op_Nop, Op_Add, Op_Cancel, Op_Modify} op_t;
    typedef enum logic [1:0] {Rsp_Ack, Rsp_Rej, Rsp_Fill} rsp_code_t;
    typedef struct packed {
        op_t         op;
        uid_t        uid;
        logic        side;
        logic [15:0] price;
        logic [15:0] qty;
    } cmd_t;
    typedef struct packed {
        uid_t        uid;
        rsp_code_t   code;
        logic [15:0] qty;
    } rsp_t;
    typedef struct packed {
        uid_t     uid;
        port_id_t port;
    } inflight_t;
    localparam uid_t UID_OB_INITIATED = '1;
endpackage

// File: rtl/ob_cmd_arb_if.sv
// ob_cmd_arb_if: ingress command ports, engine command/response channels,
// per-port response outputs, trade output and status of the command arbiter.
// slave = arbiter view, master = environment view.
interface ob_cmd_arb_if #(
    parameter int PORTS_N    = cfg_pkg::ARB_PORTS_N,
    parameter int INFLIGHT_N = cfg_pkg::ARB_INFLIGHT_N
);
    import ob_pkg::*;
    logic [PORTS_N-1:0]           in_vld;
    cmd_t [PORTS_N-1:0]           in_cmd;
    logic [PORTS_N-1:0]           in_accept;
    logic                         ob_cmd_vld;
    cmd_t                         ob_cmd;
    logic                         ob_cmd_accept;
    logic                         ob_rsp_vld;
    rsp_t                         ob_rsp;
    logic                         ob_rsp_accept;
    logic [PORTS_N-1:0]           out_rsp_vld;
    rsp_t                         out_rsp;
    logic [PORTS_N-1:0]           out_rsp_accept;
    logic                         trd_vld;
    rsp_t                         trd;
    logic                         trd_accept;
    logic [$clog2(INFLIGHT_N):0]  inflight_cnt;
    logic                         err_mismatch;
    modport slave (
        input  in_vld, in_cmd, ob_cmd_accept, ob_rsp_vld, ob_rsp, out_rsp_accept, trd_accept,
        output in_accept, ob_cmd_vld, ob_cmd, ob_rsp_accept, out_rsp_vld, out_rsp,
               trd_vld, trd, inflight_cnt, err_mismatch
    );
    modport master (
        output in_vld, in_cmd, ob_cmd_accept, ob_rsp_vld, ob_rsp, out_rsp_accept, trd_accept,
        input  in_accept, ob_cmd_vld, ob_cmd, ob_rsp_accept, out_rsp_vld, out_rsp,
               trd_vld, trd, inflight_cnt, err_mismatch
    );
endinterface

// File: rtl/libv_queue.sv
// libv_queue: generic synchronous FIFO with first-word head view.
// push/push_data write, pop advances head; empty/full/count report occupancy.
module libv_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count
);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    assign head  = mem[rd_ptr];
    assign empty = count == '0;
    assign full  = count == FULL_CNT;
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end
    always_ff @(posedge clk) if (push) mem[wr_ptr] <= push_data;
endmodule

// File: rtl/ob_cmd_arb_rr.sv
// ob_cmd_arb_rr: combinational round-robin picker.
// req: requests, ptr: highest-priority port; gnt: one-hot winner, gnt_id: its index.
module ob_cmd_arb_rr
    import ob_pkg::*;
#(
    parameter int PORTS_N = cfg_pkg::ARB_PORTS_N
) (
    input  logic [PORTS_N-1:0] req,
    input  port_id_t           ptr,
    output logic [PORTS_N-1:0] gnt,
    output port_id_t           gnt_id
);
    port_id_t idx;
    // Scan from farthest to nearest so the last hit is the first requester at/after ptr.
    always_comb begin
        gnt = '0;
        gnt_id = '0;
        idx = '0;
        for (int i = PORTS_N - 1; i >= 0; i--) begin
            idx = port_id_t'((int'(ptr) + i) % PORTS_N);
            if (req[idx]) begin
                gnt = '0;
                gnt[idx] = 1'b1;
                gnt_id = idx;
            end
        end
    end
endmodule

// File: rtl/ob_cmd_arb.sv
// ob_cmd_arb: round-robin merge of ingress command ports into the order-book
// engine, with in-order response steering back to the issuing port.
// clk/rst: clock and sync active-high reset; bus: all command/response channels.
// PORTS_N must not exceed cfg_pkg::ARB_PORTS_N, which sizes port_id_t.
module ob_cmd_arb
    import ob_pkg::*;
#(
    parameter int PORTS_N    = cfg_pkg::ARB_PORTS_N,
    parameter int INFLIGHT_N = cfg_pkg::ARB_INFLIGHT_N
) (
    input logic         clk,
    input logic         rst,
    ob_cmd_arb_if.slave bus
);
    logic [PORTS_N-1:0] req, gnt;
    logic [$bits(inflight_t)-1:0] push_data, head_raw;
    logic full, empty, can_issue, any_gnt, issue, rsp_vld, is_trd, route, drop, pop;
    port_id_t gnt_id, rr_ptr;
    cmd_t win_cmd;
    inflight_t head;
    // Fullness is the registered count, so a same-cycle pop never frees a slot for a grant.
    assign can_issue = !rst && !full && (!bus.ob_cmd_vld || bus.ob_cmd_accept);
    assign req = can_issue ? bus.in_vld : '0;
    ob_cmd_arb_rr #(.PORTS_N(PORTS_N)) u_rr (
        .req(req),
        .ptr(rr_ptr),
        .gnt(gnt),
        .gnt_id(gnt_id)
    );
    assign any_gnt = |gnt;
    assign win_cmd = bus.in_cmd[gnt_id];
    assign issue = any_gnt && win_cmd.op != Op_Nop;
    assign bus.in_accept = gnt;
    assign push_data = {win_cmd.uid, gnt_id};
    libv_queue #(.WIDTH($bits(inflight_t)), .DEPTH(INFLIGHT_N)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(issue),
        .push_data(push_data),
        .pop(pop),
        .head(head_raw),
        .empty(empty),
        .full(full),
        .count(bus.inflight_cnt)
    );
    assign head = inflight_t'(head_raw);
    // Trades bypass the FIFO; everything else follows the in-flight head, even on uid mismatch.
    assign rsp_vld = bus.ob_rsp_vld && !rst;
    assign is_trd = bus.ob_rsp.uid == UID_OB_INITIATED;
    assign route = rsp_vld && !is_trd && !empty;
    assign drop = rsp_vld && !is_trd && empty;
    assign pop = route && bus.out_rsp_accept[head.port];
    assign bus.trd_vld = rsp_vld && is_trd;
    assign bus.out_rsp_vld = route ? PORTS_N'(1) << head.port : '0;
    assign bus.ob_rsp_accept = bus.trd_vld ? bus.trd_accept : pop || drop;
    assign bus.out_rsp = bus.ob_rsp;
    assign bus.trd = bus.ob_rsp;
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ob_cmd_vld <= 1'b0;
            bus.err_mismatch <= 1'b0;
            rr_ptr <= '0;
        end else begin
            bus.ob_cmd_vld <= issue || (bus.ob_cmd_vld && !bus.ob_cmd_accept);
            if (any_gnt) rr_ptr <= (int'(gnt_id) == PORTS_N - 1) ? '0 : gnt_id + 1'b1;
            if (drop || (pop && bus.ob_rsp.uid != head.uid)) bus.err_mismatch <= 1'b1;
        end
    end
    always_ff @(posedge clk) if (issue) bus.ob_cmd <= win_cmd;
endmodule

// File: doc/ob_cmd_arb.md
# ob_cmd_arb

Command arbiter and response router in front of the order-book matching engine. It merges command streams from `PORTS_N` ingress ports into the engine's single command interface using round-robin arbitration. It records the issuing port of each in-flight command and steers each engine response back to that port. OB-initiated trade responses go to a dedicated trade output.

## Interface
- `PORTS_N`, 2: number of ingress command ports (2..8).
- `INFLIGHT_N`, 8: maximum commands issued to the engine and not yet answered (power of 2).
- `clk` in 1: sole clock.
- `rst` in 1: reset, synchronous, active-high.
- `in_vld` in `PORTS_N`: per-port command valid.
- `in_cmd` in `PORTS_N` x `ob_pkg::cmd_t`: per-port command.
- `in_accept` out `PORTS_N`: one-hot; command taken this cycle.
- `ob_cmd_vld` out 1: command to engine valid (registered).
- `ob_cmd` out `ob_pkg::cmd_t`: command to engine (registered).
- `ob_cmd_accept` in 1: engine takes `ob_cmd` this cycle.
- `ob_rsp_vld` in 1: engine response valid.
- `ob_rsp` in `ob_pkg::rsp_t`: engine response.
- `ob_rsp_accept` out 1: response consumed this cycle.
- `out_rsp_vld` out `PORTS_N`: one-hot; response for port p valid.
- `out_rsp` out `ob_pkg::rsp_t`: response bus, shared by all ports.
- `out_rsp_accept` in `PORTS_N`: per-port response accept.
- `trd_vld` out 1: OB-initiated trade response valid.
- `trd` out `ob_pkg::rsp_t`: trade response (`uid` == '1).
- `trd_accept` in 1: trade response accept.
- `inflight_cnt` out `$clog2(INFLIGHT_N)+1`: current in-flight count.
- `err_mismatch` out 1: sticky; response `uid` differed from in-flight head.

## Operation
- Engine contract: exactly one response per non-Nop command, in issue order. Zero or more trade responses carry `uid` == '1 and are interleaved anywhere.
- Grant rule:
  - A grant is possible only if the in-flight FIFO is not full and the output register is empty or is being accepted this cycle.
  - The winner is the first `in_vld` port at or after priority pointer `rr_ptr`, wrapping modulo `PORTS_N`.
  - On a grant, `rr_ptr` becomes winner+1 (mod `PORTS_N`). With no grant, `rr_ptr` holds.
- Granted command with opcode `Op_Nop`:
  - `in_accept` asserts and the command is discarded.
  - No FIFO push, no engine issue, no response.
  - `rr_ptr` still advances.
- Other granted commands:
  - The command loads the output register.
  - `{uid, port}` pushes into the in-flight FIFO in the same cycle.
- Response path, for `ob_rsp_vld` with `uid` == '1:
  - Drive `trd_vld`, with `ob_rsp_accept` = `trd_accept`.
  - FIFO untouched.
- Response path, other `uid`:
  - Drive `out_rsp_vld[head.port]`, with `ob_rsp_accept` = `out_rsp_accept[head.port]`.
  - On the handshake, pop the FIFO.
  - If `ob_rsp.uid` != `head.uid`: still route to `head.port`, pop, and set `err_mismatch`. It is cleared only by `rst`.
- Response with FIFO empty and `uid` != '1:
  - Accept and drop it (`ob_rsp_accept`=1).
  - Set `err_mismatch`.
- Push and pop in the same cycle are legal; count is unchanged. Full means no grant, even when a pop occurs the same cycle.
- Response routing is combinational: `out_rsp` = `trd` = `ob_rsp`.

## Timing
- Reset values:
  - Outputs: `ob_cmd_vld`=0, `in_accept`=0, `out_rsp_vld`=0, `trd_vld`=0, `ob_rsp_accept`=0, `inflight_cnt`=0, `err_mismatch`=0.
  - Internal state: `rr_ptr`=0, FIFO empty.
- Command latency: `in_accept` at cycle t means `ob_cmd_vld` at t+1. Back-to-back issue runs at 1/cycle while `ob_cmd_accept` stays high.
- `ob_cmd` and `ob_cmd_vld` hold stable while `ob_cmd_accept` is low.
- Response latency: 0 cycles, `ob_rsp_vld` to `out_rsp_vld`/`trd_vld`.
- `inflight_cnt` updates the cycle after push or pop.
- Reset mid-operation: the pending output register, FIFO contents and `rr_ptr` are discarded. Engine responses to pre-reset commands arrive with an empty FIFO and flag `err_mismatch`. The engine is reset together with this block.

## Structure
- `cfg_pkg`: `ARB_PORTS_N`, `ARB_INFLIGHT_N`, which feed the parameter defaults.
- `ob_pkg`: `port_id_t` (`$clog2(ARB_PORTS_N)` bits) and `inflight_t` = packed `{uid_t uid; port_id_t port;}`. `UID_OB_INITIATED` = '1.
- Sub-module `ob_cmd_arb_rr`: combinational round-robin picker (`req`, `ptr` -> one-hot `gnt`, `gnt_id`).
- The FIFO is the existing generic libv queue, with width `$bits(inflight_t)` and depth `INFLIGHT_N`.

## Test plan
- Round-robin fairness:
  - Stimulus: `PORTS_N`=2, both ports valid continuously, uids 0x10.. on port 0 and 0x20.. on port 1, `ob_cmd_accept`=1.
  - Required: `ob_cmd.uid` order is 0x10, 0x20, 0x11, 0x21.
- Routing:
  - Stimulus: engine answers in order.
  - Required: uid 0x10 goes to `out_rsp_vld`=2'b01, uid 0x20 goes to 2'b10, and `inflight_cnt` returns to 0.
- Trade interleave:
  - Stimulus: `ob_rsp.uid`=32'hFFFF_FFFF between two normal responses.
  - Required: it appears on `trd_vld`, the FIFO does not pop, and the next normal response routes correctly.
- Full:
  - Stimulus: `INFLIGHT_N`=8, 8 commands issued with no responses.
  - Required: a 9th `in_vld` sees `in_accept`=0 until one response handshakes. The 9th is then accepted, and no grant occurs in the pop cycle itself.
- Backpressure:
  - Stimulus: `out_rsp_accept[1]`=0 for 5 cycles while a port-1 response is pending.
  - Required: `ob_rsp_accept`=0 for those 5 cycles, then a single pop.
- Nop/mismatch:
  - Stimulus: an `Op_Nop` command.
  - Required: it is accepted with no `ob_cmd_vld` and `inflight_cnt` stays 0.
  - Stimulus: a response with uid 0x99 while head is 0x10.
  - Required: routed to `head.port` and `err_mismatch`=1 until `rst`.
